seq_div16x8: RTL
================

Name: seq_div16x8

Overview:
- Iterative signed divider; the inverse operation of the 8x8 Booth multiplier path. Given a 16-bit product-width dividend and an 8-bit divisor, it recovers a 16-bit quotient and an 8-bit remainder.
- Radix-2 restoring algorithm on magnitudes, with sign fix-up. Produces one quotient bit per cycle.
- Sits beside the multiplier in the ALU datapath. Uses a start/busy/done handshake so the control unit can stall while it runs.

Parameters:
- DW, 16, dividend and quotient width (two's complement)
- VW, 8, divisor and remainder width (two's complement)

Ports:
- clk  input  1  single system clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  16  signed dividend, captured on accepted start
- divisor  input  8  signed divisor, captured on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when results are valid
- quot  output  16  signed quotient, truncated toward zero
- rem  output  8  signed remainder; sign follows the dividend
- div_zero  output  1  divisor was 0 for the last operation
- ovf  output  1  result not representable (-32768 / -1)

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - busy=0, done=0, quot=0, rem=0, div_zero=0, ovf=0.
  - Applies mid-operation too: the in-flight result is discarded and no done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, capture the operands, compute the sign flags and magnitudes, and clear the count.
  - Magnitudes: |dividend| as 16-bit unsigned (32768 representable); |divisor| as 8-bit unsigned (128 representable).
  - If divisor==0, go to DONE with quot=0, rem=0, div_zero=1, ovf=0.
  - Otherwise go to CALC.
  - start with state!=IDLE is ignored. No queueing.
- CALC (exactly 16 cycles, count 0..15):
  - Shift {partial_rem[8:0], dq[15:0]} left one bit.
  - Trial-subtract the divisor magnitude from the 9-bit partial remainder.
  - If the trial result is non-negative, keep it and set quotient bit=1; otherwise restore and set the bit to 0.
  - The 9-bit partial remainder covers values up to 255 before subtraction.
  - After count 15, go to FIX.
- FIX (1 cycle):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - ovf=1 if the dividend was -32768 and the divisor was -1; in that case quot=16'h8000 and rem=0.
  - Go to DONE.
- DONE (1 cycle): done=1, then return to IDLE.
- Latency, with the accepted start at cycle 0:
  - Normal operation: busy is high in cycles 1..18 (the CALC cycles, the FIX cycle and the DONE cycle); done=1 in cycle 18.
  - Divide-by-zero: busy=1 and done=1 in cycle 1.
- Output registers:
  - quot, rem, div_zero and ovf update only when entering DONE.
  - They hold their values until the next DONE or reset.
  - busy and done are registered outputs, not combinational.
- Back-to-back: start may be asserted in the cycle done=1 (state is DONE, so it is ignored). The earliest accepted start is the cycle after done.
- Invariant when div_zero=0 and ovf=0: dividend == quot*divisor + rem, with |rem| < |divisor|.

Decomposition:
- Shared alu_pkg holds:
  - state enum (IDLE, CALC, FIX, DONE)
  - DW/VW constants
  - CNT_W=4
- One natural sub-module, div_step: combinational shift/trial-subtract/select for one radix-2 iteration. Instantiated once and reused every CALC cycle.
- The control FSM and the sign handling stay in the top module.

Test Plan:
- 1000 / 7 -> done at cycle 18: quot=16'h008E (142), rem=8'h06, div_zero=0, ovf=0.
- -1000 / 7 -> quot=16'hFF72 (-142), rem=8'hFA (-6); 12345 / -128 -> quot=16'hFFA0 (-96), rem=8'h39 (57).
- -32768 / -1 -> ovf=1, quot=16'h8000, rem=0; -32768 / 1 -> quot=16'h8000, ovf=0.
- 500 / 0 -> done at cycle 1, div_zero=1, quot=0, rem=0.
- start pulsed in cycles 5 and 18 of an active 1000/7 operation -> both ignored, a single done at cycle 18; a new start in cycle 19 yields its own done at cycle 37.
- reset_n=0 in cycle 9 of an operation -> busy=0 next cycle, all outputs 0, no done pulse. A random sweep of 10k operands is checked against the invariant.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths and the divider control states.
package alu_pkg;

  localparam int DW    = 16;
  localparam int VW    = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring-division iteration on magnitudes: shift, trial-subtract, select.
module div_step
  import alu_pkg::*;
(
  input  logic [VW-1:0] pr_in,
  input  logic [DW-1:0] dq_in,
  input  logic [VW-1:0] dvs,
  output logic [VW-1:0] pr_out,
  output logic [DW-1:0] dq_out
);

  logic [VW:0]   shifted;
  logic          fits;
  logic [VW-1:0] diff;

  // The partial remainder stays below |divisor| <= 128, so after the shift it
  // needs 9 bits, and the kept difference always fits back into 8.
  assign shifted = {pr_in, dq_in[DW-1]};
  assign fits    = (shifted >= {1'b0, dvs});
  assign diff    = shifted[VW-1:0] - dvs;

  assign pr_out  = fits ? diff : shifted[VW-1:0];
  assign dq_out  = {dq_in[DW-2:0], fits};

endmodule

// File: rtl/seq_div16x8.sv
// Iterative signed 16/8 divider: restoring division on magnitudes, then sign fix-up.
module seq_div16x8
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quot,
  output logic [VW-1:0] rem,
  output logic          div_zero,
  output logic          ovf
);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [VW-1:0]   pr;
  logic [DW-1:0]   dq;
  logic [VW-1:0]   dvs_mag;
  logic            neg_q;
  logic            neg_r;
  logic            ovf_pend;

  logic [VW-1:0]   pr_next;
  logic [DW-1:0]   dq_next;
  logic [DW-1:0]   dd_abs;
  logic [VW-1:0]   dv_abs;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1) unsigned.
  assign dd_abs = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
  assign dv_abs = divisor[VW-1]  ? (~divisor + 1'b1)  : divisor;

  div_step u_step (
    .pr_in  (pr),
    .dq_in  (dq),
    .dvs    (dvs_mag),
    .pr_out (pr_next),
    .dq_out (dq_next)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking assignments would make ordering within the block matter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pr       <= '0;
      dq       <= '0;
      dvs_mag  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            pr       <= '0;
            dq       <= dd_abs;
            dvs_mag  <= dv_abs;
            neg_q    <= dividend[DW-1] ^ divisor[VW-1];
            neg_r    <= dividend[DW-1];
            ovf_pend <= (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == {VW{1'b1}});
            busy     <= 1'b1;
            if (divisor == '0) begin
              quot     <= '0;
              rem      <= '0;
              div_zero <= 1'b1;
              ovf      <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          pr  <= pr_next;
          dq  <= dq_next;
          cnt <= cnt + 1'b1;
          if (cnt == {CNT_W{1'b1}}) state <= FIX;
        end

        FIX: begin
          div_zero <= 1'b0;
          ovf      <= ovf_pend;
          if (ovf_pend) begin
            quot <= {1'b1, {(DW-1){1'b0}}};
            rem  <= '0;
          end else begin
            quot <= neg_q ? (~dq + 1'b1) : dq;
            rem  <= neg_r ? (~pr + 1'b1) : pr;
          end
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
